// File: rtl/tour_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tour_checker: knight-tour monitor with legality, revisit, watchdog checks  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tour_checker #(
  parameter int BOARD_DIM    = 5,
  parameter int COORD_W      = 3,
  parameter int TIMEOUT_CLKS = 1000000,
  parameter int CNT_W        = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pos_vld,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  output logic               tracking,
  output logic               tour_done,
  output logic               err,
  output logic [2:0]         err_code,
  output logic [CNT_W-1:0]   move_cnt,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y
);

  localparam int CELLS = BOARD_DIM * BOARD_DIM;
  localparam int IDX_W = $clog2(CELLS);
  localparam int WD_W  = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRACK = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  localparam logic [2:0] E_NONE    = 3'd0;
  localparam logic [2:0] E_OFF     = 3'd1;
  localparam logic [2:0] E_ILLEGAL = 3'd2;
  localparam logic [2:0] E_REVISIT = 3'd3;
  localparam logic [2:0] E_TIMEOUT = 3'd4;
  localparam logic [2:0] E_OVERRUN = 3'd5;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CELLS - 1);
  localparam logic [COORD_W:0] DIM_C    = (COORD_W + 1)'(BOARD_DIM);
  localparam logic [COORD_W:0] ONE_C    = (COORD_W + 1)'(1);
  localparam logic [COORD_W:0] TWO_C    = (COORD_W + 1)'(2);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [2:0]         r_err_code;
  logic [2:0]         w_code_nxt;
  logic [CELLS-1:0]   r_visited;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [COORD_W-1:0] r_cur_x;
  logic [COORD_W-1:0] r_cur_y;

  logic               w_on_board;
  logic [IDX_W-1:0]   w_idx;
  logic signed [COORD_W:0] w_dx;
  logic signed [COORD_W:0] w_dy;
  logic [COORD_W:0]   w_adx;
  logic [COORD_W:0]   w_ady;
  logic               w_is_l;
  logic               w_seen;
  logic               w_clear;
  logic               w_mark_start;
  logic               w_accept;
  logic               w_wd_expired;

  assign w_on_board = ({1'b0, pos_x} < DIM_C) && ({1'b0, pos_y} < DIM_C);
  assign w_idx      = IDX_W'(pos_y) * IDX_W'(BOARD_DIM) + IDX_W'(pos_x);
  assign w_seen     = r_visited[w_idx];

  // One extra bit on the differences keeps them exact, so no modular wrap.
  assign w_dx  = $signed({1'b0, pos_x}) - $signed({1'b0, r_cur_x});
  assign w_dy  = $signed({1'b0, pos_y}) - $signed({1'b0, r_cur_y});
  assign w_adx = w_dx[COORD_W] ? $unsigned(-w_dx) : $unsigned(w_dx);
  assign w_ady = w_dy[COORD_W] ? $unsigned(-w_dy) : $unsigned(w_dy);
  assign w_is_l = ((w_adx == ONE_C) && (w_ady == TWO_C)) ||
                  ((w_adx == TWO_C) && (w_ady == ONE_C));

  assign w_cnt_inc = r_cnt + 1'b1;

  generate
    if (TIMEOUT_CLKS > 0) begin : g_wd_on
      localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CLKS - 1);
      logic [WD_W-1:0] r_wd;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_wd <= '0;
        end else if (start || pos_vld || (w_state_nxt != S_TRACK)) begin
          r_wd <= '0;
        end else begin
          r_wd <= r_wd + 1'b1;
        end
      end

      assign w_wd_expired = (r_wd == WD_LAST);
    end else begin : g_wd_off
      assign w_wd_expired = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // start outranks everything; a concurrent pos_vld is dropped.
  always_comb begin
    w_state_nxt  = r_state;
    w_code_nxt   = r_err_code;
    w_clear      = 1'b0;
    w_mark_start = 1'b0;
    w_accept     = 1'b0;
    if (start) begin
      w_clear = 1'b1;
      if (w_on_board) begin
        w_state_nxt  = S_TRACK;
        w_code_nxt   = E_NONE;
        w_mark_start = 1'b1;
      end else begin
        w_state_nxt = S_ERR;
        w_code_nxt  = E_OFF;
      end
    end else begin
      case (r_state)
        S_TRACK: begin
          if (pos_vld) begin
            if (!w_on_board) begin
              w_state_nxt = S_ERR;
              w_code_nxt  = E_OFF;
            end else if (!w_is_l) begin
              w_state_nxt = S_ERR;
              w_code_nxt  = E_ILLEGAL;
            end else if (w_seen) begin
              w_state_nxt = S_ERR;
              w_code_nxt  = E_REVISIT;
            end else begin
              w_accept = 1'b1;
              if (w_cnt_inc == LAST_CNT) begin
                w_state_nxt = S_DONE;
              end
            end
          end else if (w_wd_expired) begin
            w_state_nxt = S_ERR;
            w_code_nxt  = E_TIMEOUT;
          end
        end
        S_DONE: begin
          if (pos_vld) begin
            w_state_nxt = S_ERR;
            w_code_nxt  = E_OVERRUN;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_code <= E_NONE;
      r_visited  <= '0;
      r_cnt      <= '0;
      r_cur_x    <= '0;
      r_cur_y    <= '0;
    end else begin
      r_err_code <= w_code_nxt;
      if (w_clear) begin
        r_visited <= '0;
        r_cnt     <= '0;
        if (w_mark_start) begin
          r_visited[w_idx] <= 1'b1;
          r_cur_x          <= pos_x;
          r_cur_y          <= pos_y;
        end
      end else if (w_accept) begin
        r_visited[w_idx] <= 1'b1;
        r_cur_x          <= pos_x;
        r_cur_y          <= pos_y;
        r_cnt            <= w_cnt_inc;
      end
    end
  end

  always_comb begin
    tracking  = (r_state == S_TRACK);
    tour_done = (r_state == S_DONE);
    err       = (r_state == S_ERR);
    err_code  = r_err_code;
    move_cnt  = r_cnt;
    cur_x     = r_cur_x;
    cur_y     = r_cur_y;
  end

endmodule
`default_nettype wire

// File: tb/tb_tour_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tour_checker: scoreboard bench for tour_checker (5x5, timeout 100)      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_tour_checker;

  localparam int N  = 5;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pos_vld;
  logic [2:0] pos_x;
  logic [2:0] pos_y;
  logic       tracking;
  logic       tour_done;
  logic       err;
  logic [2:0] err_code;
  logic [6:0] move_cnt;
  logic [2:0] cur_x;
  logic [2:0] cur_y;

  tour_checker #(
    .BOARD_DIM    (N),
    .COORD_W      (3),
    .TIMEOUT_CLKS (TO),
    .CNT_W        (7)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pos_vld   (pos_vld),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .tracking  (tracking),
    .tour_done (tour_done),
    .err       (err),
    .err_code  (err_code),
    .move_cnt  (move_cnt),
    .cur_x     (cur_x),
    .cur_y     (cur_y)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       trk;
    logic       done;
    logic       err;
    logic [2:0] code;
    logic [6:0] cnt;
    logic [2:0] cx;
    logic [2:0] cy;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: 0 idle, 1 track, 2 done, 3 err
  int        m_state = 0;
  int        m_code  = 0;
  int        m_cnt   = 0;
  int        m_cx    = 0;
  int        m_cy    = 0;
  int        m_wd    = 0;
  bit [24:0] m_vis   = '0;

  int tour_x[24] = '{2, 4, 3, 4, 2, 0, 1, 2, 4, 3, 1, 0, 1, 3, 4, 2, 0, 1, 3, 4, 3, 1, 0, 2};
  int tour_y[24] = '{1, 0, 2, 4, 3, 4, 2, 0, 1, 3, 4, 2, 0, 1, 3, 4, 3, 1, 0, 2, 4, 3, 1, 2};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit v, input int x, input int y);
    int  adx;
    int  ady;
    bit  onb;
    onb = (x < N) && (y < N);
    adx = (x > m_cx) ? x - m_cx : m_cx - x;
    ady = (y > m_cy) ? y - m_cy : m_cy - y;
    if (r) begin
      m_state = 0; m_code = 0; m_cnt = 0; m_cx = 0; m_cy = 0; m_wd = 0; m_vis = '0;
    end else if (s) begin
      m_vis = '0; m_cnt = 0; m_wd = 0;
      if (onb) begin
        m_vis[y*N+x] = 1'b1; m_cx = x; m_cy = y; m_state = 1; m_code = 0;
      end else begin
        m_state = 3; m_code = 1;
      end
    end else if (m_state == 1) begin
      if (v) begin
        m_wd = 0;
        if (!onb) begin
          m_state = 3; m_code = 1;
        end else if (!((adx == 1 && ady == 2) || (adx == 2 && ady == 1))) begin
          m_state = 3; m_code = 2;
        end else if (m_vis[y*N+x]) begin
          m_state = 3; m_code = 3;
        end else begin
          m_vis[y*N+x] = 1'b1; m_cx = x; m_cy = y; m_cnt++;
          if (m_cnt == N*N-1) m_state = 2;
        end
      end else begin
        m_wd++;
        if (m_wd == TO) begin
          m_state = 3; m_code = 4;
        end
      end
    end else if (m_state == 2 && v) begin
      m_state = 3; m_code = 5;
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit v, input int x, input int y);
    exp_t e;
    rst = r; start = s; pos_vld = v;
    pos_x = x[2:0]; pos_y = y[2:0];
    model_step(r, s, v, x, y);
    e.trk  = (m_state == 1);
    e.done = (m_state == 2);
    e.err  = (m_state == 3);
    e.code = m_code[2:0];
    e.cnt  = m_cnt[6:0];
    e.cx   = m_cx[2:0];
    e.cy   = m_cy[2:0];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("tracking",  32'(tracking),  32'(e.trk));
    check("tour_done", 32'(tour_done), 32'(e.done));
    check("err",       32'(err),       32'(e.err));
    check("err_code",  32'(err_code),  32'(e.code));
    check("move_cnt",  32'(move_cnt),  32'(e.cnt));
    check("cur_x",     32'(cur_x),     32'(e.cx));
    check("cur_y",     32'(cur_y),     32'(e.cy));
    rst = 1'b0; start = 1'b0; pos_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time bound");
    $fatal(1, "time bound expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; pos_vld = 1'b0; pos_x = '0; pos_y = '0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);

    // Single legal move
    cyc(0, 1, 0, 2, 2);
    cyc(0, 0, 1, 4, 3);
    idle(2);

    // Illegal L, then ignored update in ERR
    cyc(0, 1, 0, 2, 2);
    cyc(0, 0, 1, 3, 3);
    cyc(0, 0, 1, 4, 3);
    idle(1);

    // Revisit, then restart clears
    cyc(0, 1, 0, 2, 2);
    cyc(0, 0, 1, 4, 3);
    cyc(0, 0, 1, 2, 2);
    cyc(0, 1, 0, 3, 0);
    idle(1);

    // Off-board move and off-board start; start+pos_vld together
    cyc(0, 1, 0, 3, 1);
    cyc(0, 0, 1, 5, 2);
    cyc(0, 1, 0, 7, 0);
    idle(2);
    cyc(0, 1, 1, 1, 1);
    idle(1);

    // Full tour, then overrun
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 24; i++) cyc(0, 0, 1, tour_x[i], tour_y[i]);
    idle(2);
    cyc(0, 0, 1, 4, 3);
    idle(2);

    // Watchdog expiry exactly TO clocks after start
    cyc(0, 1, 0, 2, 2);
    idle(TO + 3);

    // Move on the expiry clock is processed, then reset mid-tour
    cyc(0, 1, 0, 2, 2);
    idle(TO - 1);
    cyc(0, 0, 1, 4, 3);
    idle(5);
    cyc(0, 0, 1, 3, 1);
    cyc(1, 0, 0, 0, 0);
    idle(2);

    // Random move traffic against the model
    for (int k = 0; k < 6; k++) begin
      cyc(0, 1, 0, $urandom_range(0, 4), $urandom_range(0, 4));
      for (int j = 0; j < 25; j++)
        cyc(0, 0, $urandom_range(0, 1), $urandom_range(0, 5), $urandom_range(0, 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
